// File: rtl/spi_controller.sv
// ---------------------------------------------------------------------------
// spi_controller
//   SPI master (mode 0) that sends one 16-bit frame {wr, addr[6:0], wdata[7:0]}
//   MSB first. nCS is held low for the 16 bits plus one trailing half-period.
//   nCS then stays high for at least CS_GAP cycles before the next frame.
//
//   Parameters
//     CLK_DIV : SCLK half-period in clk cycles (2..255)
//     CS_GAP  : minimum nCS-high cycles between frames (1..255)
//
//   Optional feature (macro SPI_CONTROLLER_READ_EN)
//     defined   : frame bit 15 = wr. cipo is sampled on each sclk rise
//                 for frame bits 7:0. rd_data is loaded at done of read frames.
//     undefined : frame bit 15 is forced to 1, cipo is ignored,
//                 and rd_data stays 8'h00.
//
//   Ports
//     clk, rst_n          : clock (rising edge), async active-low reset
//     start, wr, addr,    : frame request and contents. They are sampled only
//     wdata                 on the accept edge (start=1 while ready=1).
//     ready               : high only in IDLE
//     done                : one-cycle pulse in the first IDLE cycle after a frame
//     rd_data             : byte captured during the last read frame
//     sclk, ncs, copi     : SPI outputs (sclk idles low, ncs idles high)
//     cipo                : SPI input from the peripheral
//     dbg_state           : current FSM state (IDLE=0, SHIFT=1, TAIL=2, GAP=3)
//
//   Handshake: the request is accepted on the rising edge where start=1 and
//   ready=1. ready drops from the next cycle and returns with done, in the same
//   cycle. A new start in that cycle is accepted at once.
// ---------------------------------------------------------------------------
module spi_controller #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       wr,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       ready,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       sclk,
    output logic       ncs,
    output logic       copi,
    input  logic       cipo,
    output logic [1:0] dbg_state
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = $clog2(CS_GAP + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        TAIL  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bit_q, bit_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [15:0]      sr_q, sr_d;
    logic             sclk_q, sclk_d;
    logic             ncs_q, ncs_d;
    logic             copi_q, copi_d;
    logic             done_q, done_d;
    logic             first_bit;
    logic [15:0]      frame_in;
    logic             unused_bits;

`ifdef SPI_CONTROLLER_READ_EN
    logic [7:0] rx_q, rx_d;
    logic [7:0] rd_q, rd_d;
    logic       rd_frame_q, rd_frame_d;

    assign first_bit   = wr;
    assign rd_data     = rd_q;
    // The MSB has already been copied to copi when the frame is accepted.
    assign unused_bits = sr_q[15];
`else
    assign first_bit   = 1'b1;
    assign rd_data     = 8'h00;
    assign unused_bits = ^{wr, cipo, sr_q[15]};
`endif

    assign frame_in  = {first_bit, addr, wdata};
    assign ready     = (state_q == IDLE);
    assign done      = done_q;
    assign sclk      = sclk_q;
    assign ncs       = ncs_q;
    assign copi      = copi_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sr_d    = sr_q;
        sclk_d  = sclk_q;
        ncs_d   = ncs_q;
        copi_d  = copi_q;
        done_d  = 1'b0;
`ifdef SPI_CONTROLLER_READ_EN
        rx_d       = rx_q;
        rd_d       = rd_q;
        rd_frame_d = rd_frame_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    sr_d    = frame_in;
                    div_d   = '0;
                    bit_d   = 5'd0;
                    ncs_d   = 1'b0;
                    sclk_d  = 1'b0;
                    copi_d  = frame_in[15];
`ifdef SPI_CONTROLLER_READ_EN
                    rd_frame_d = ~wr;
`endif
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        // Rising edge: the peripheral's bit is stable now.
                        sclk_d = 1'b1;
`ifdef SPI_CONTROLLER_READ_EN
                        if (bit_q >= 5'd8) begin
                            rx_d = {rx_q[6:0], cipo};
                        end
`endif
                    end else begin
                        // Falling edge: advance to the next bit, or finish
                        // after the 16th bit.
                        sclk_d = 1'b0;
                        if (bit_q == 5'd15) begin
                            state_d = TAIL;
                        end else begin
                            bit_d  = bit_q + 5'd1;
                            sr_d   = {sr_q[14:0], 1'b0};
                            copi_d = sr_q[14];
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            TAIL: begin
                if (div_q == DIV_LAST) begin
                    state_d = GAP;
                    div_d   = '0;
                    gap_d   = '0;
                    ncs_d   = 1'b1;
                    copi_d  = 1'b0;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                    done_d  = 1'b1;
`ifdef SPI_CONTROLLER_READ_EN
                    if (rd_frame_q) begin
                        rd_d = rx_q;
                    end
`endif
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= 5'd0;
            gap_q   <= '0;
            sr_q    <= 16'h0000;
            sclk_q  <= 1'b0;
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SPI_CONTROLLER_READ_EN
            rx_q       <= 8'h00;
            rd_q       <= 8'h00;
            rd_frame_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            sr_q    <= sr_d;
            sclk_q  <= sclk_d;
            ncs_q   <= ncs_d;
            copi_q  <= copi_d;
            done_q  <= done_d;
`ifdef SPI_CONTROLLER_READ_EN
            rx_q       <= rx_d;
            rd_q       <= rd_d;
            rd_frame_q <= rd_frame_d;
`endif
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// ---------------------------------------------------------------------------
// tb_spi_controller
//   Directed and random frames for spi_controller with CLK_DIV=4 and CS_GAP=4.
//   Each output is compared on every clk falling edge against a waveform
//   model. The model is built from the frame timeline: bits occupy
//   32*CLK_DIV cycles, the tail lasts CLK_DIV cycles, the gap lasts CS_GAP
//   cycles, and done comes after that.
//   A small peripheral model drives cipo from a response byte.
//   The SPI_CONTROLLER_READ_EN setting follows the RTL build.
// ---------------------------------------------------------------------------
module tb_spi_controller;
    localparam int D       = 4;
    localparam int G       = 4;
    localparam int NCS_LOW = 33 * D;
    localparam int K_DONE  = 33 * D + G + 1;
`ifdef SPI_CONTROLLER_READ_EN
    localparam bit READ_EN = 1'b1;
`else
    localparam bit READ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       wr = 1'b0;
    logic [6:0] addr = 7'h00;
    logic [7:0] wdata = 8'h00;
    logic       ready, done, sclk, ncs, copi, cipo;
    logic [7:0] rd_data;
    logic [1:0] dbg_state;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] resp = 8'h00;
    logic [7:0] exp_rd = 8'h00;
    int         fall_cnt = 0;
    logic       sclk_prev = 1'b0;
    int         high_run = 0;
    int         last_gap = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    spi_controller #(.CLK_DIV(D), .CS_GAP(G)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wr(wr), .addr(addr),
        .wdata(wdata), .ready(ready), .done(done), .rd_data(rd_data),
        .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo),
        .dbg_state(dbg_state)
    );

    // Peripheral: after n sclk falls in a frame, it presents response
    // bit (15-n) for frame positions 7..0.
    always @(posedge clk) begin
        sclk_prev <= sclk;
        if (ncs) fall_cnt <= 0;
        else if (sclk_prev && !sclk) fall_cnt <= fall_cnt + 1;
    end

    always_comb begin
        cipo = 1'b0;
        if (fall_cnt >= 8 && fall_cnt <= 15) cipo = resp[3'(15 - fall_cnt)];
    end

    // Length of the most recent complete nCS-high run.
    always @(posedge clk) begin
        if (ncs) high_run <= high_run + 1;
        else begin
            if (high_run != 0) last_gap <= high_run;
            high_run <= 0;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Runs one frame starting at a falling edge with ready=1.
    // disturb_k : cycle offset at which start is pulsed with altered data (0 = never)
    // reset_k   : cycle offset at which rst_n is asserted (0 = never)
    // hold      : keep start high so that the next frame follows back-to-back
    // chk_gap   : check the nCS-high run that came before this frame
    task automatic do_frame(input logic f_wr, input logic [6:0] f_addr,
                            input logic [7:0] f_wdata, input logic [7:0] f_resp,
                            input bit hold, input bit chk_gap,
                            input int disturb_k, input int reset_k);
        logic [15:0] exp_frame;
        logic [15:0] got_word;
        logic        sclk_last;
        logic        exp_sclk;
        int          rises;
        exp_frame = {(READ_EN ? f_wr : 1'b1), f_addr, f_wdata};
        check("ready_before_start", {15'd0, ready}, 16'd1);
        resp  = f_resp;
        start = 1'b1;
        wr    = f_wr;
        addr  = f_addr;
        wdata = f_wdata;
        got_word  = 16'h0000;
        sclk_last = 1'b0;
        rises     = 0;
        for (int k = 1; k <= K_DONE; k++) begin
            @(negedge clk);
            if (k == reset_k) begin
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                check("rst_ncs",   {15'd0, ncs},  16'd1);
                check("rst_sclk",  {15'd0, sclk}, 16'd0);
                check("rst_copi",  {15'd0, copi}, 16'd0);
                check("rst_done",  {15'd0, done}, 16'd0);
                check("rst_rdata", {8'd0, rd_data}, 16'd0);
                exp_rd = 8'h00;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                for (int j = 1; j <= K_DONE; j++) begin
                    @(negedge clk);
                    check("post_rst_ready", {15'd0, ready}, 16'd1);
                    check("post_rst_done",  {15'd0, done},  16'd0);
                    check("post_rst_ncs",   {15'd0, ncs},   16'd1);
                    check("post_rst_sclk",  {15'd0, sclk},  16'd0);
                end
                return;
            end
            if (k == 1 && !hold) start = 1'b0;
            if (k == disturb_k) begin
                start = 1'b1;
                wr    = ~f_wr;
                addr  = ~f_addr;
                wdata = ~f_wdata;
            end
            if (k == disturb_k + 1 && !hold) start = 1'b0;
            if (k == 2 && chk_gap) check("ncs_gap_len", 16'(last_gap), 16'(G + 1));

            exp_sclk = (k <= 32 * D) && (((k - 1) / D) % 2 == 1);
            check("ncs",  {15'd0, ncs},  {15'd0, (k > NCS_LOW)});
            check("sclk", {15'd0, sclk}, {15'd0, exp_sclk});
            if (k <= 32 * D)
                check("copi", {15'd0, copi}, {15'd0, exp_frame[15 - (k - 1) / (2 * D)]});
            else if (k > NCS_LOW)
                check("copi_idle", {15'd0, copi}, 16'd0);
            check("done",  {15'd0, done},  {15'd0, (k == K_DONE)});
            check("ready", {15'd0, ready}, {15'd0, (k == K_DONE)});

            if (sclk && !sclk_last) begin
                got_word = {got_word[14:0], copi};
                rises++;
            end
            sclk_last = sclk;
        end
        check("sclk_rises", 16'(rises), 16'd16);
        check("frame_word", got_word, exp_frame);
        if (READ_EN && !f_wr) exp_rd = f_resp;
        check("rd_data", {8'd0, rd_data}, {8'd0, exp_rd});
        if (hold) begin
            // Next frame's contents go in now; start is still high.
            wr    = 1'b0;
            addr  = 7'h00;
            wdata = 8'h00;
        end
    endtask

    initial begin
        // ---------------- reset ----------------
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", {15'd0, ready}, 16'd1);
        check("reset_done",  {15'd0, done},  16'd0);
        check("reset_ncs",   {15'd0, ncs},   16'd1);
        check("reset_sclk",  {15'd0, sclk},  16'd0);
        check("reset_copi",  {15'd0, copi},  16'd0);
        check("reset_rdata", {8'd0, rd_data}, 16'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_ready", {15'd0, ready}, 16'd1);

        // Directed write, 16'h84A5.
        do_frame(1'b1, 7'h04, 8'hA5, 8'($urandom), 1'b0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);
        // Directed read; the peripheral answers 8'h3C.
        do_frame(1'b0, 7'h02, 8'h00, 8'h3C, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        // Start pulse with altered data mid-frame must be ignored.
        do_frame(1'b1, 7'h55, 8'h3E, 8'h81, 1'b0, 1'b0, 50, 0);
        // A write frame keeps rd_data unchanged.
        do_frame(1'b1, 7'h7F, 8'hFF, 8'h00, 1'b0, 1'b0, 0, 0);
        // Start held high: two frames back-to-back.
        do_frame(1'b0, 7'h11, 8'h22, 8'hC3, 1'b1, 1'b0, 70, 0);
        do_frame(1'b1, 7'h6A, 8'h5A, 8'h18, 1'b0, 1'b1, 0, 0);

        // Random frames with random idle spacing (0 = accept in done cycle).
        for (int n = 0; n < 6; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            do_frame(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
                     1'b0, 1'b0, (n % 2 == 1) ? int'($urandom_range(5, 120)) : 0, 0);
        end

        // Reset asserted mid-frame, then one normal frame afterwards.
        do_frame(1'b0, 7'h33, 8'h99, 8'hE7, 1'b0, 1'b0, 0, 60);
        do_frame(1'b0, 7'h40, 8'h01, 8'h5B, 1'b0, 1'b0, 0, 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
